// File: rtl/stopwatch_counter.sv
// SS.hh stopwatch: start/stop/clear FSM, hundredth-tick prescaler and a four-digit
// bank advanced through a chain of limited incrementers (59.99 -> 00.00 wrap).

`timescale 1ns/1ps

module lim_inc #(
    parameter int L = 9,
    parameter int W = $clog2(L) + 1
) (
    input  logic [W-1:0] a,
    input  logic         ci,
    output logic [W-1:0] sum,
    output logic         co
);

    // Increment by ci, wrapping to zero (and carrying out) when a sits at the limit
    always_comb begin
        co = ci && (a == W'(L));
        if (co) begin
            sum = '0;
        end else begin
            sum = a + W'(ci);
        end
    end

endmodule

module stopwatch_counter #(
    parameter int PRESCALE = 1_000_000,
    parameter int LIM_LO   = 9,
    parameter int LIM_HI   = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       clear,
    output logic [3:0] dig0,
    output logic [3:0] dig1,
    output logic [3:0] dig2,
    output logic [3:0] dig3,
    output logic       running,
    output logic       wrap
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int WL = $clog2(LIM_LO) + 1;
    localparam int WH = $clog2(LIM_HI) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic          tick;

    // Digit registers keep the full incrementer width so the wide sum feeds straight back
    logic [WL-1:0] d0, d1, d2;
    logic [WH-1:0] d3;
    logic [WL-1:0] s0, s1, s2;
    logic [WH-1:0] s3;
    logic          co0, co1, co2, co3;

    assign tick = (state == RUN) && (presc == PW'(PRESCALE - 1));

    lim_inc #(.L(LIM_LO), .W(WL)) u_inc0 (.a(d0), .ci(1'b1), .sum(s0), .co(co0));
    lim_inc #(.L(LIM_LO), .W(WL)) u_inc1 (.a(d1), .ci(co0),  .sum(s1), .co(co1));
    lim_inc #(.L(LIM_LO), .W(WL)) u_inc2 (.a(d2), .ci(co1),  .sum(s2), .co(co2));
    lim_inc #(.L(LIM_HI), .W(WH)) u_inc3 (.a(d3), .ci(co2),  .sum(s3), .co(co3));

    assign dig0 = 4'(d0);
    assign dig1 = 4'(d1);
    assign dig2 = 4'(d2);
    assign dig3 = 4'(d3);

    // Control FSM, prescaler and digit bank; clear overrides start_stop in every state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            presc   <= '0;
            d0      <= '0;
            d1      <= '0;
            d2      <= '0;
            d3      <= '0;
            running <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (clear) begin
                state   <= IDLE;
                presc   <= '0;
                d0      <= '0;
                d1      <= '0;
                d2      <= '0;
                d3      <= '0;
                running <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        presc <= '0;
                        d0    <= '0;
                        d1    <= '0;
                        d2    <= '0;
                        d3    <= '0;
                        if (start_stop) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end else begin
                            state   <= IDLE;
                            running <= 1'b0;
                        end
                    end
                    RUN: begin
                        if (tick) begin
                            presc <= '0;
                            d0    <= s0;
                            d1    <= s1;
                            d2    <= s2;
                            d3    <= s3;
                            wrap  <= co3;
                        end else begin
                            presc <= presc + PW'(1);
                        end
                        if (start_stop) begin
                            state   <= PAUSE;
                            running <= 1'b0;
                        end else begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                    PAUSE: begin
                        if (start_stop) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end else begin
                            state   <= PAUSE;
                            running <= 1'b0;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        presc   <= '0;
                        d0      <= '0;
                        d1      <= '0;
                        d2      <= '0;
                        d3      <= '0;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
